// File: rtl/apb_completer.sv
// APB completer backed by a small byte-strobed register file.
// Responses are fully registered and stretched by a fixed number of wait states.
module apb_completer #(
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned STRB_WIDTH  = DATA_WIDTH / 8,
  parameter int unsigned NUM_REGS    = 16,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [STRB_WIDTH-1:0] PSTRB,
  output logic                  PREADY,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PSLVERR
);

  localparam int unsigned ALIGNBITS = $clog2(STRB_WIDTH);
  localparam int unsigned IDXBITS   = $clog2(NUM_REGS);

  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(STRB_WIDTH - 1);
  localparam logic [ADDR_WIDTH-1:0] REG_LIMIT  = ADDR_WIDTH'(NUM_REGS);
  localparam logic [3:0]            WAIT_INIT  = 4'(WAIT_STATES);

  typedef enum logic [0:0] {StIdle, StAccess} state_e;

  state_e                r_state;
  logic [3:0]            r_cnt;
  logic                  r_ready;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_slverr;
  logic                  r_write;
  logic                  r_err;
  logic [IDXBITS-1:0]    r_idx;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_WIDTH-1:0] r_strb;
  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

  logic [ADDR_WIDTH-1:0] w_word;
  logic [IDXBITS-1:0]    w_idx;
  logic                  w_err;

  always_comb begin
    w_word = PADDR >> ALIGNBITS;
    w_idx  = PADDR[ALIGNBITS +: IDXBITS];
    w_err  = (|(PADDR & ALIGN_MASK)) || (w_word >= REG_LIMIT);
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_state  <= StIdle;
      r_cnt    <= '0;
      r_ready  <= 1'b0;
      r_rdata  <= '0;
      r_slverr <= 1'b0;
      r_write  <= 1'b0;
      r_err    <= 1'b0;
      r_idx    <= '0;
      r_wdata  <= '0;
      r_strb   <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      unique case (r_state)
        StIdle: begin
          // PENABLE high without a preceding setup phase is ignored here.
          if (PSEL && !PENABLE) begin
            r_state  <= StAccess;
            r_write  <= PWRITE;
            r_err    <= w_err;
            r_idx    <= w_idx;
            r_wdata  <= PWDATA;
            r_strb   <= PSTRB;
            r_cnt    <= WAIT_INIT;
            r_ready  <= (WAIT_STATES == 0);
            r_slverr <= w_err;
            r_rdata  <= (!PWRITE && !w_err) ? r_regs[w_idx] : '0;
          end
        end
        StAccess: begin
          if (!PSEL) begin
            r_state  <= StIdle;
            r_ready  <= 1'b0;
            r_rdata  <= '0;
            r_slverr <= 1'b0;
          end else if (PENABLE) begin
            if (r_ready) begin
              if (r_write && !r_err) begin
                for (int b = 0; b < STRB_WIDTH; b++) begin
                  if (r_strb[b]) begin
                    r_regs[r_idx][8*b +: 8] <= r_wdata[8*b +: 8];
                  end
                end
              end
              r_state  <= StIdle;
              r_ready  <= 1'b0;
              r_rdata  <= '0;
              r_slverr <= 1'b0;
            end else begin
              r_cnt   <= r_cnt - 4'd1;
              r_ready <= (r_cnt == 4'd1);
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign PREADY  = r_ready;
  assign PRDATA  = r_rdata;
  assign PSLVERR = r_slverr;

endmodule

// File: tb/tb_apb_completer.sv
// Bench for apb_completer: two instances (1 and 0 wait states) checked against
// a word-array reference model, a directed vector table and corner sequences.
module tb_apb_completer;

  logic        pclk;
  logic        preset;
  logic        psel    [2];
  logic        penable [2];
  logic        pwrite  [2];
  logic [15:0] paddr   [2];
  logic [31:0] pwdata  [2];
  logic [3:0]  pstrb   [2];
  logic        pready  [2];
  logic [31:0] prdata  [2];
  logic        pslverr [2];

  int vectors;
  int miscompares;

  int          ws [2];
  logic [31:0] mem [2][16];

  apb_completer #(.WAIT_STATES(1)) u_dut_ws1 (
    .PCLK(pclk), .PRESET(preset), .PSEL(psel[0]), .PENABLE(penable[0]),
    .PWRITE(pwrite[0]), .PADDR(paddr[0]), .PWDATA(pwdata[0]), .PSTRB(pstrb[0]),
    .PREADY(pready[0]), .PRDATA(prdata[0]), .PSLVERR(pslverr[0])
  );

  apb_completer #(.WAIT_STATES(0)) u_dut_ws0 (
    .PCLK(pclk), .PRESET(preset), .PSEL(psel[1]), .PENABLE(penable[1]),
    .PWRITE(pwrite[1]), .PADDR(paddr[1]), .PWDATA(pwdata[1]), .PSTRB(pstrb[1]),
    .PREADY(pready[1]), .PRDATA(prdata[1]), .PSLVERR(pslverr[1])
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t tbl [18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 16; i++) mem[d][i] = 32'h0;
  endtask

  // Word-addressed memory view: an access is legal only on a 4-byte boundary below 64.
  task automatic model_xfer(input int d, input logic wr, input logic [15:0] addr,
                            input logic [31:0] wdata, input logic [3:0] strb,
                            output logic [31:0] rdata, output logic err);
    int word;
    word  = int'(addr) / 4;
    err   = (int'(addr) % 4 != 0) || (word >= 16);
    rdata = (!wr && !err) ? mem[d][word] : 32'h0;
    if (wr && !err) begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) mem[d][word][8*b +: 8] = wdata[8*b +: 8];
    end
  endtask

  // Entered at a falling edge; leaves at the falling edge after the completion edge
  // with the bus still in access, so a following call is back-to-back.
  task automatic bus_xfer(input int d, input logic wr, input logic [15:0] addr,
                          input logic [31:0] wdata, input logic [3:0] strb,
                          output logic [31:0] rdata, output logic err, output int cycles);
    psel[d]    = 1'b1;
    penable[d] = 1'b0;
    pwrite[d]  = wr;
    paddr[d]   = addr;
    pwdata[d]  = wdata;
    pstrb[d]   = strb;
    @(negedge pclk);
    penable[d] = 1'b1;
    cycles = 1;
    while (!pready[d] && cycles < 40) begin
      @(negedge pclk);
      cycles++;
    end
    rdata = prdata[d];
    err   = pslverr[d];
    @(negedge pclk);
  endtask

  task automatic idle(input int d, input int n);
    psel[d]    = 1'b0;
    penable[d] = 1'b0;
    repeat (n) @(negedge pclk);
  endtask

  task automatic do_xfer(input int d, input string tag, input logic wr, input logic [15:0] addr,
                         input logic [31:0] wdata, input logic [3:0] strb,
                         output logic [31:0] rdata, output logic err);
    logic [31:0] m_rdata;
    logic        m_err;
    int          cycles;
    model_xfer(d, wr, addr, wdata, strb, m_rdata, m_err);
    bus_xfer(d, wr, addr, wdata, strb, rdata, err, cycles);
    check($sformatf("%s d%0d %s@%h rdata", tag, d, wr ? "W" : "R", addr), rdata, m_rdata);
    check($sformatf("%s d%0d %s@%h slverr", tag, d, wr ? "W" : "R", addr), 32'(err), 32'(m_err));
    check($sformatf("%s d%0d %s@%h ready_cycle", tag, d, wr ? "W" : "R", addr),
          32'(cycles), 32'(ws[d] + 1));
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    logic        wr;
    logic [15:0] addr;

    vectors     = 0;
    miscompares = 0;
    ws[0]       = 1;
    ws[1]       = 0;
    model_clear();

    tbl[0]  = '{1'b0, 16'h0004, 32'h00000000, 4'h0, 32'h00000000, 1'b0};
    tbl[1]  = '{1'b1, 16'h0008, 32'hDEADBEEF, 4'hF, 32'h00000000, 1'b0};
    tbl[2]  = '{1'b0, 16'h0008, 32'h00000000, 4'h0, 32'hDEADBEEF, 1'b0};
    tbl[3]  = '{1'b1, 16'h0008, 32'h11223344, 4'h5, 32'h00000000, 1'b0};
    tbl[4]  = '{1'b0, 16'h0008, 32'h00000000, 4'h0, 32'hDE22BE44, 1'b0};
    tbl[5]  = '{1'b1, 16'h0006, 32'hFFFFFFFF, 4'hF, 32'h00000000, 1'b1};
    tbl[6]  = '{1'b1, 16'h0040, 32'hFFFFFFFF, 4'hF, 32'h00000000, 1'b1};
    tbl[7]  = '{1'b0, 16'h0004, 32'h00000000, 4'h0, 32'h00000000, 1'b0};
    tbl[8]  = '{1'b0, 16'h0000, 32'h00000000, 4'h0, 32'h00000000, 1'b0};
    tbl[9]  = '{1'b0, 16'h0008, 32'h00000000, 4'hF, 32'hDE22BE44, 1'b0};
    tbl[10] = '{1'b0, 16'h000A, 32'h00000000, 4'h0, 32'h00000000, 1'b1};
    tbl[11] = '{1'b1, 16'h000C, 32'hCAFEF00D, 4'hF, 32'h00000000, 1'b0};
    tbl[12] = '{1'b0, 16'h000C, 32'h00000000, 4'h0, 32'hCAFEF00D, 1'b0};
    tbl[13] = '{1'b1, 16'h0010, 32'h00000055, 4'h0, 32'h00000000, 1'b0};
    tbl[14] = '{1'b0, 16'h0010, 32'h00000000, 4'h0, 32'h00000000, 1'b0};
    tbl[15] = '{1'b1, 16'h003C, 32'h0BADF00D, 4'hF, 32'h00000000, 1'b0};
    tbl[16] = '{1'b0, 16'h003C, 32'h00000000, 4'h0, 32'h0BADF00D, 1'b0};
    tbl[17] = '{1'b0, 16'h0040, 32'h00000000, 4'h0, 32'h00000000, 1'b1};

    preset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
      paddr[d] = '0; pwdata[d] = '0; pstrb[d] = '0;
    end
    repeat (3) @(negedge pclk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset d%0d pready", d), 32'(pready[d]), 32'h0);
      check($sformatf("reset d%0d prdata", d), prdata[d], 32'h0);
      check($sformatf("reset d%0d pslverr", d), 32'(pslverr[d]), 32'h0);
    end
    preset = 1'b0;
    @(negedge pclk);

    // Directed table, every row back-to-back with the previous one.
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 18; i++) begin
        do_xfer(d, $sformatf("tbl%0d", i), tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].strb,
                rd, er);
        check($sformatf("tbl%0d d%0d table_rdata", i, d), rd, tbl[i].exp_rdata);
        check($sformatf("tbl%0d d%0d table_slverr", i, d), 32'(er), 32'(tbl[i].exp_err));
      end
      idle(d, 2);
    end

    // PENABLE high in IDLE with no setup phase must not start a transfer.
    psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b1;
    paddr[0] = 16'h0000; pwdata[0] = 32'hFFFFFFFF; pstrb[0] = 4'hF;
    for (int i = 0; i < 3; i++) begin
      @(negedge pclk);
      check($sformatf("idle_penable cyc%0d pready", i), 32'(pready[0]), 32'h0);
    end
    idle(0, 1);
    do_xfer(0, "idle_penable", 1'b0, 16'h0000, 32'h0, 4'h0, rd, er);
    idle(0, 1);

    // Abort: PSEL dropped in ACCESS just before the completion edge.
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1;
    paddr[0] = 16'h0014; pwdata[0] = 32'h77777777; pstrb[0] = 4'hF;
    @(negedge pclk);
    penable[0] = 1'b1;
    @(negedge pclk);
    check("abort pready_before", 32'(pready[0]), 32'h1);
    psel[0] = 1'b0; penable[0] = 1'b0;
    @(negedge pclk);
    check("abort pready_after", 32'(pready[0]), 32'h0);
    check("abort prdata_after", prdata[0], 32'h0);
    do_xfer(0, "abort", 1'b0, 16'h0014, 32'h0, 4'h0, rd, er);
    idle(0, 1);

    // Randomised traffic, mostly legal addresses, random idle gaps.
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 150; i++) begin
        wr = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 7) == 0) addr = 16'($urandom_range(0, 16'h5F));
        else addr = 16'($urandom_range(0, 15) * 4);
        do_xfer(d, "rand", wr, addr, $urandom, 4'($urandom), rd, er);
        if ($urandom_range(0, 2) != 0) idle(d, int'($urandom_range(1, 2)));
      end
      idle(d, 1);
    end

    // Reset during an in-flight write on both instances.
    do_xfer(0, "pre_rst", 1'b1, 16'h0000, 32'hAAAA5555, 4'hF, rd, er);
    idle(0, 1);
    do_xfer(1, "pre_rst", 1'b1, 16'h0000, 32'hAAAA5555, 4'hF, rd, er);
    idle(1, 1);
    for (int d = 0; d < 2; d++) begin
      psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = 1'b1;
      paddr[d] = 16'h0000; pwdata[d] = 32'h12345678; pstrb[d] = 4'hF;
    end
    @(negedge pclk);
    penable[0] = 1'b1;
    penable[1] = 1'b1;
    check("rst_mid ws1 pready_wait", 32'(pready[0]), 32'h0);
    check("rst_mid ws0 pready_ready", 32'(pready[1]), 32'h1);
    #2 preset = 1'b1;
    #1;
    check("rst_mid ws1 pready", 32'(pready[0]), 32'h0);
    check("rst_mid ws0 pready", 32'(pready[1]), 32'h0);
    check("rst_mid ws0 pslverr", 32'(pslverr[1]), 32'h0);
    @(negedge pclk);
    idle(0, 0);
    idle(1, 0);
    @(negedge pclk);
    preset = 1'b0;
    model_clear();
    @(negedge pclk);
    do_xfer(0, "post_rst", 1'b0, 16'h0000, 32'h0, 4'h0, rd, er);
    do_xfer(0, "post_rst", 1'b0, 16'h003C, 32'h0, 4'h0, rd, er);
    idle(0, 1);
    do_xfer(1, "post_rst", 1'b0, 16'h0000, 32'h0, 4'h0, rd, er);
    do_xfer(1, "post_rst", 1'b0, 16'h000C, 32'h0, 4'h0, rd, er);
    idle(1, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/apb_completer.md
Name: apb_completer

Overview:
- APB completer (peripheral-side responder) backed by a small register file; the responder end of the manager FSM (IDLE/SETUP/ACCESS) defined in apb_pkg.
- Decodes PADDR, inserts a programmable number of wait states, performs byte-strobed writes and returns read data.
- Flags misaligned or out-of-range accesses with PSLVERR.
- Sits on the APB bus alongside other completers; takes bus widths and validAlign from apb_pkg.

Parameters:
- ADDR_WIDTH, 16, address bus width (apb_pkg value).
- DATA_WIDTH, 32, data bus width; legal values 8, 16, 32.
- STRB_WIDTH, DATA_WIDTH/8, write strobe width.
- NUM_REGS, 16, register count; power of two, ≥2.
- WAIT_STATES, 1, wait cycles inserted per transfer; legal range 0..15.

Ports:
- PCLK  input  1  bus clock; all state updates on the rising edge.
- PRESET  input  1  reset; asynchronous, active-high.
- PSEL  input  1  completer select.
- PENABLE  input  1  access phase indicator.
- PWRITE  input  1  1 = write, 0 = read.
- PADDR  input  ADDR_WIDTH  byte address.
- PWDATA  input  DATA_WIDTH  write data.
- PSTRB  input  STRB_WIDTH  byte lanes for a write; PSTRB[n] covers PWDATA[8n+7:8n].
- PREADY  output  1  transfer completes this cycle.
- PRDATA  output  DATA_WIDTH  read data; valid only when PREADY=1.
- PSLVERR  output  1  error response; valid only when PREADY=1.

Behaviour:
- Reset (asynchronous, immediate):
  - FSM goes to IDLE.
  - PREADY=0, PRDATA=0, PSLVERR=0.
  - Wait counter = 0.
  - All registers = 0.
  - Any in-flight transfer is dropped with no write.
- FSM states: IDLE and ACCESS.
- IDLE:
  - On an edge sampling PSEL=1 and PENABLE=0 (setup phase), capture PADDR, PWRITE, PWDATA and PSTRB, then go to ACCESS.
  - At the same edge:
    - cnt ← WAIT_STATES.
    - PREADY ← (WAIT_STATES==0).
    - PSLVERR ← err.
    - PRDATA ← read value.
  - Read value = reg[idx] for a legal read; 0 for a write or an error.
- Address decode:
  - idx = PADDR[ALIGNBITS +: log2(NUM_REGS)].
  - err = !validAlign(PADDR) OR (PADDR >> ALIGNBITS) ≥ NUM_REGS.
- ACCESS, while PREADY=0:
  - Each edge with PSEL=1 and PENABLE=1: cnt ← cnt−1; PREADY ← (cnt==1).
  - Net effect: PREADY goes high in access cycle WAIT_STATES+1.
- ACCESS, completion edge (PSEL=1, PENABLE=1, PREADY=1):
  - If it is a write and err=0, each reg[idx] byte lane with PSTRB=1 takes the matching PWDATA byte; other lanes are unchanged.
  - PREADY, PRDATA and PSLVERR go to 0; FSM returns to IDLE.
  - A following setup phase on the next edge is accepted normally, giving back-to-back transfers with no idle cycle.
- Read-after-write: a read whose setup immediately follows a write's completion returns the newly written value, because the write commits before the read captures.
- PSTRB is ignored on reads. A write with PSTRB=0 completes with PSLVERR=0 and changes no register.
- Error transfers:
  - Same wait-state timing as legal transfers.
  - PSLVERR=1, PRDATA=0, no register change.
- Protocol abort: PSEL=0 sampled in ACCESS before completion → return to IDLE, clear outputs, no write.
- PENABLE=1 sampled in IDLE (no preceding setup) is ignored.
- Outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset, then read addr 0x0004 with WAIT_STATES=1 → PREADY high in the 2nd access cycle, PRDATA=0x00000000, PSLVERR=0.
- Write 0xDEADBEEF to 0x0008 with PSTRB=4'b1111, then read 0x0008 → PRDATA=0xDEADBEEF.
- Write 0x11223344 with PSTRB=4'b0101 over 0xDEADBEEF at 0x0008, then read → PRDATA=0xDE22BE44.
- Write to 0x0006 (misaligned) and to 0x0040 (index 16, out of range) → PSLVERR=1 at PREADY, PRDATA=0, all registers unchanged.
- Back-to-back: write 0xCAFEF00D to 0x000C immediately followed by a read of 0x000C; repeat with WAIT_STATES=0 → read returns 0xCAFEF00D; PREADY asserted in the first access cycle.
- Assert PRESET during an access wait cycle of a write of 0x12345678 to 0x0000 → PREADY=0 immediately; a subsequent read of 0x0000 returns 0.
